// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo.
// master: producer/consumer side; slave: the FIFO itself.
interface param_fifo_if #(
  parameter int N     = 32,
  parameter int DEPTH = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          PushEn;
  logic [N-1:0]  PushVal;
  logic          PullEn;
  logic [N-1:0]  PullVal;
  logic          PullValid;
  logic          IsFull;
  logic          IsEmpty;
  logic          AlmostFull;
  logic          AlmostEmpty;
  logic [CW-1:0] Count;
  logic          Overflow;
  logic          Underflow;

  modport master (
    output PushEn, PushVal, PullEn,
    input  PullVal, PullValid, IsFull, IsEmpty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );

  modport slave (
    input  PushEn, PushVal, PullEn,
    output PullVal, PullValid, IsFull, IsEmpty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-2) depth, occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; default build uses
// a registered read port.
module param_fifo #(
  parameter int N      = 32,
  parameter int DEPTH  = 5,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Pwr_off,
  param_fifo_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          underflow_q;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pull_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is allowed when a pull frees a slot in the same cycle.
  assign push_ok = bus.PushEn && (!full || bus.PullEn);
  assign pull_ok = bus.PullEn && !empty;

  // Pointers, occupancy and error pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (Pwr_off) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.PushEn && !push_ok;
      underflow_q <= bus.PullEn && !pull_ok;
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pull_ok) rd_ptr <= next_ptr(rd_ptr);
      if (push_ok && !pull_ok)      count <= count + 1'b1;
      else if (pull_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge Clk) begin
    if (push_ok && !Pwr_off) mem[wr_ptr] <= bus.PushVal;
  end

  assign bus.Count       = count;
  assign bus.IsFull      = full;
  assign bus.IsEmpty     = empty;
  assign bus.AlmostFull  = (count >= CW'(AF_LVL));
  assign bus.AlmostEmpty = (count <= CW'(AE_LVL));
  assign bus.Overflow    = overflow_q;
  assign bus.Underflow   = underflow_q;

`ifdef FIFO_FWFT_EN
  // Head entry is presented directly; gated to zero so unwritten storage never leaks.
  assign bus.PullVal   = empty ? '0 : mem[rd_ptr];
  assign bus.PullValid = !empty;
`else
  logic [N-1:0] pull_val_q;
  logic         pull_valid_q;

  // Registered read port: data lands the cycle after an accepted pull, then holds.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pull_val_q   <= '0;
      pull_valid_q <= 1'b0;
    end else if (Pwr_off) begin
      pull_val_q   <= '0;
      pull_valid_q <= 1'b0;
    end else begin
      pull_valid_q <= pull_ok;
      if (pull_ok) pull_val_q <= mem[rd_ptr];
    end
  end

  assign bus.PullVal   = pull_val_q;
  assign bus.PullValid = pull_valid_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed scoreboard bench for param_fifo (default registered-read build),
// DEPTH=5, AF_LVL=4, AE_LVL=1.
module tb_param_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwr_off = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  param_fifo_if #(.N(32), .DEPTH(5)) bus ();

  param_fifo #(.N(32), .DEPTH(5), .AF_LVL(4), .AE_LVL(1)) dut (
    .Clk(clk),
    .Rst(rst),
    .Pwr_off(pwr_off),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs return to idle 1ns after the edge.
  task automatic step(input logic push, input logic [31:0] val, input logic pull, input logic pwr);
    bus.PushEn  = push;
    bus.PushVal = val;
    bus.PullEn  = pull;
    pwr_off     = pwr;
    @(posedge clk);
    #1;
    bus.PushEn = 1'b0;
    bus.PullEn = 1'b0;
    pwr_off    = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    step(1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic pull(input logic [31:0] v);
    exp_q.push_back(v);
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(bus.Count), 0);
    chk({tag, "_empty"}, 32'(bus.IsEmpty), 1);
    chk({tag, "_full"}, 32'(bus.IsFull), 0);
    chk({tag, "_ae"}, 32'(bus.AlmostEmpty), 1);
    chk({tag, "_af"}, 32'(bus.AlmostFull), 0);
    chk({tag, "_pullval"}, bus.PullVal, 0);
    chk({tag, "_pullvalid"}, 32'(bus.PullValid), 0);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 0);
    chk({tag, "_unf"}, 32'(bus.Underflow), 0);
  endtask

  // Monitor: every presented output word must match the oldest expected pull.
  always @(negedge clk) begin
    if (rst && bus.PullValid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pull: got 0x%0h expected no output at %0t", bus.PullVal, $time);
      end else begin
        chk("pull_data", bus.PullVal, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PushEn  = 1'b0;
    bus.PushVal = '0;
    bus.PullEn  = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk_reset_outputs("rst");
    @(negedge clk) rst = 1'b1;

    // Fill A1..A5
    for (int i = 0; i < 5; i++) begin
      push(32'hA1 + 32'(i));
      chk("fill_count", 32'(bus.Count), 32'(i + 1));
      chk("fill_af", 32'(bus.AlmostFull), (i >= 3) ? 1 : 0);
      chk("fill_full", 32'(bus.IsFull), (i == 4) ? 1 : 0);
    end

    // Push while full, no pull
    push(32'hA6);
    chk("ovf_pulse", 32'(bus.Overflow), 1);
    chk("ovf_count", 32'(bus.Count), 5);
    idle();
    chk("ovf_clear", 32'(bus.Overflow), 0);

    // Drain 6 times
    for (int i = 0; i < 5; i++) begin
      pull(32'hA1 + 32'(i));
      chk("drain_count", 32'(bus.Count), 32'(4 - i));
    end
    chk("drain_empty", 32'(bus.IsEmpty), 1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_pulse", 32'(bus.Underflow), 1);
    chk("unf_novalid", 32'(bus.PullValid), 0);
    idle();
    chk("unf_clear", 32'(bus.Underflow), 0);

    // Pointer wrap
    push(32'h01); push(32'h02); push(32'h03);
    pull(32'h01); pull(32'h02); pull(32'h03);
    for (int i = 0; i < 5; i++) push(32'hB0 + 32'(i));
    for (int i = 0; i < 5; i++) pull(32'hB0 + 32'(i));
    idle();
    chk("wrap_empty", 32'(bus.IsEmpty), 1);

    // Simultaneous push/pull at full
    for (int i = 0; i < 5; i++) push(32'hD0 + 32'(i));
    exp_q.push_back(32'hD0);
    step(1'b1, 32'hD5, 1'b1, 1'b0);
    chk("simfull_count", 32'(bus.Count), 5);
    chk("simfull_noovf", 32'(bus.Overflow), 0);
    for (int i = 1; i < 6; i++) pull(32'hD0 + 32'(i));
    chk("simfull_drained", 32'(bus.Count), 0);

    // Simultaneous push/pull at empty
    step(1'b1, 32'hE0, 1'b1, 1'b0);
    chk("simempty_count", 32'(bus.Count), 1);
    chk("simempty_unf", 32'(bus.Underflow), 1);
    chk("simempty_novalid", 32'(bus.PullValid), 0);
    pull(32'hE0);

    // Asynchronous reset mid-operation at Count=3
    push(32'h11); push(32'h12); push(32'h13);
    chk("pre_arst_count", 32'(bus.Count), 3);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk) rst = 1'b1;
    push(32'hC0);
    pull(32'hC0);
    idle();
    chk("hold_val", bus.PullVal, 32'hC0);
    chk("hold_novalid", 32'(bus.PullValid), 0);

    // Synchronous power-off clear, with a concurrent push ignored
    push(32'hF1); push(32'hF2);
    pull(32'hF1);
    step(1'b1, 32'hF3, 1'b0, 1'b1);
    chk_reset_outputs("pwroff");
    push(32'hC0);
    pull(32'hC0);
    idle();
    chk("pwroff_after_empty", 32'(bus.IsEmpty), 1);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
